mod_n_counter: RTL and testbench

- Synchronous modulo-N up-counter. Counts 0, 1, …, N-1 and then wraps to 0.
- Used as a generic divider/sequencer in control paths: clock-enable generation, slot indexing, and periodic strobes.
- Provides the count value, a terminal-count flag and a one-cycle wrap strobe.

---
 rtl/mod_n_counter_pkg.sv | 17 +
 rtl/mod_n_counter.sv | 66 ++++++
 tb/tb_mod_n_counter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mod_n_counter_pkg.sv
// Shared constants and width helper for the modulo-N counter.
package mod_n_counter_pkg;

  localparam int unsigned DEFAULT_N      = 6;
  localparam int unsigned DEFAULT_LENGTH = 3;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned req_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'(1) << w) < 64'(n))) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with terminal-count flag and one-cycle wrap strobe.
// Optional synchronous load port enabled by defining MOD_N_COUNTER_LOAD_EN.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int unsigned N      = DEFAULT_N,
  parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
`ifdef MOD_N_COUNTER_LOAD_EN
  input  logic              load,
  input  logic [LENGTH-1:0] load_val,
`endif
  output logic [LENGTH-1:0] counter,
  output logic              tc,
  output logic              wrap
);

  // Reject moduli that cannot be represented in LENGTH bits.
  if ((N < 2) || (req_width(N) > LENGTH)) begin : g_bad_params
    $fatal(1, "mod_n_counter: N=%0d illegal for LENGTH=%0d", N, LENGTH);
  end

  localparam logic [LENGTH-1:0] LAST = LENGTH'(N - 1);

  logic [LENGTH-1:0] counter_d, counter_q;
  logic              wrap_d, wrap_q;

  // Next count; out-of-range values fall into the non-wrapping reload path.
  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
    if (clr) begin
      counter_d = '0;
`ifdef MOD_N_COUNTER_LOAD_EN
    end else if (load) begin
      counter_d = (load_val <= LAST) ? load_val : '0;
`endif
    end else if (en) begin
      if (counter_q < LAST) begin
        counter_d = counter_q + LENGTH'(1);
      end else begin
        counter_d = '0;
        wrap_d    = (counter_q == LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
    end
  end

  assign counter = counter_q;
  assign wrap    = wrap_q;
  assign tc      = (counter_q == LAST);

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench: a modulo-6 and a modulo-8 counter driven in lockstep.
module tb_mod_n_counter;

  localparam int unsigned NA = 6;
  localparam int unsigned NB = 8;
  localparam int unsigned L  = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [L-1:0] load_val = '0;
  logic [L-1:0] cnt_a, cnt_b;
  logic         tc_a, tc_b, wrap_a, wrap_b;

  always #5 clk = ~clk;

  mod_n_counter #(.N(NA), .LENGTH(L)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
`ifdef MOD_N_COUNTER_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .counter(cnt_a), .tc(tc_a), .wrap(wrap_a)
  );

  mod_n_counter #(.N(NB), .LENGTH(L)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
`ifdef MOD_N_COUNTER_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .counter(cnt_b), .tc(tc_b), .wrap(wrap_b)
  );

  typedef struct {
    int ca; bit ta; bit wa;
    int cb; bit tb; bit wb;
  } exp_t;

  exp_t exp_q[$];
  int   model_a = 0;
  int   model_b = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   load_on;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Reference behaviour for one clock edge of a modulus-n counter.
  function automatic void advance(input int n, input int cin,
                                  output int cout, output bit w);
    w    = 1'b0;
    cout = cin;
    if (!reset) cout = 0;
    else if (clr) cout = 0;
    else if (load_on && load) cout = (int'(load_val) < n) ? int'(load_val) : 0;
    else if (en) begin
      w    = (cin == n - 1);
      cout = (cin >= n - 1) ? 0 : cin + 1;
    end
  endfunction

  // Apply inputs mid-cycle, then record the expected state after the edge.
  task automatic step(input bit r, input bit e, input bit c,
                      input bit ld = 1'b0, input int lv = 0);
    exp_t x;
    @(negedge clk);
    #1;
    reset = r; en = e; clr = c; load = ld; load_val = L'(lv);
    @(posedge clk);
    advance(NA, model_a, model_a, x.wa);
    advance(NB, model_b, model_b, x.wb);
    x.ca = model_a; x.ta = (model_a == NA - 1);
    x.cb = model_b; x.tb = (model_b == NB - 1);
    exp_q.push_back(x);
  endtask

  // Drop reset between edges and confirm the outputs clear before any edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_cnt_a", int'(cnt_a), 0);
    check("async_cnt_b", int'(cnt_b), 0);
    check("async_wrap", int'({wrap_a, wrap_b}), 0);
    check("async_tc", int'({tc_a, tc_b}), 0);
    model_a = 0;
    model_b = 0;
  endtask

  // Monitor: outputs are valid every cycle; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cnt_a", int'(cnt_a), e.ca);
        check("tc_a", int'(tc_a), int'(e.ta));
        check("wrap_a", int'(wrap_a), int'(e.wa));
        check("cnt_b", int'(cnt_b), e.cb);
        check("tc_b", int'(tc_b), int'(e.tb));
        check("wrap_b", int'(wrap_b), int'(e.wb));
      end
    end
  end

  initial begin
`ifdef MOD_N_COUNTER_LOAD_EN
    load_on = 1'b1;
`else
    load_on = 1'b0;
`endif
    // Held in reset with en high.
    step(0, 1, 0);
    step(0, 1, 0);
    // Free count across two wraps of the modulo-6 instance.
    for (int i = 0; i < 13; i++) step(1, 1, 0);
    // Bring A to 3, then gate the enable.
    step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 1, 0);
    // Clear wins over a pending wrap, and clears mid-count.
    step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 1);
    // Asynchronous reset mid-count, hold, then resume.
    step(1, 1, 0);
    async_reset();
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
`ifdef MOD_N_COUNTER_LOAD_EN
    step(1, 1, 0, 1, 4);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0, 1, 7);
    step(1, 1, 1, 1, 3);
`endif
    // Randomized traffic with sparse clears, loads and reset pulses.
    for (int i = 0; i < 400; i++) begin
      if (i % 131 == 77) async_reset();
      step((i % 131 == 77) ? 1'b0 : 1'b1,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0,
           load_on && ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, 7)));
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
